// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and default widths for the handshaked pipeline stage register.
package pipe_stage_skid_pkg;

  localparam int DATA_W_DEF = 40;
  localparam int RG_W_DEF   = 4;
  localparam int WE_W_DEF   = 2;
  localparam int CNT_W_DEF  = 16;
  localparam int OCC_W      = 2;

  // One entry travelling between pipeline stages, at the default widths.
  typedef struct packed {
    logic                  kill;
    logic [WE_W_DEF-1:0]   we;
    logic [RG_W_DEF-1:0]   rg;
    logic [DATA_W_DEF-1:0] data;
  } stage_entry_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones, cleared only by reset.
module sat_counter
  import pipe_stage_skid_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step by one when enabled, but never wrap past all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a 2-entry skid buffer (main M drives
// the outputs, skid S absorbs one extra entry), flush and a stall counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RG_W   = RG_W_DEF,
  parameter int WE_W   = WE_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_kill,
  input  logic [WE_W-1:0]   in_we,
  input  logic [RG_W-1:0]   in_rg,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kill,
  output logic [WE_W-1:0]   out_we,
  output logic [RG_W-1:0]   out_rg,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              kill;
    logic [WE_W-1:0]   we;
    logic [RG_W-1:0]   rg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d, in_entry;
  logic   m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic   acc, drn;

  assign in_entry = '{kill: in_kill, we: in_we, rg: in_rg, data: in_data};

  // Readiness depends only on the skid register, so out_ready never reaches in_ready.
  assign in_ready = !s_vld_q;
  assign acc      = in_valid && in_ready;
  assign drn      = m_vld_q && out_ready;

  // Next-state of M/S: S is only ever filled while M is held, so S valid
  // implies M valid and no accept can coincide with S being occupied.
  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || drn) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (acc) begin
        m_d     = in_entry;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (acc) begin
      s_d     = in_entry;
      s_vld_d = 1'b1;
    end
  end

  // Storage registers; reset clears payload too so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (m_vld_q && !out_ready),
    .cnt_o (stall_cnt)
  );

  assign out_valid = m_vld_q;
  assign out_kill  = m_q.kill;
  assign out_we    = m_q.we & ~{WE_W{m_q.kill}};
  assign out_rg    = m_q.rg;
  assign out_data  = m_q.data;
  assign occ       = {1'b0, m_vld_q} + {1'b0, s_vld_q};

  // A held skid entry without a main entry would break FIFO order.
  a_no_orphan_skid : assert property (@(posedge clk) disable iff (!rst_n) !(s_vld_q && !m_vld_q));

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_kill;
  logic [1:0]  in_we;
  logic [3:0]  in_rg;
  logic [39:0] in_data;
  logic        out_valid, out_ready, out_kill;
  logic [1:0]  out_we;
  logic [3:0]  out_rg;
  logic [39:0] out_data;
  logic [1:0]  occ;
  logic [3:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(40), .RG_W(4), .WE_W(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kill   (in_kill),
    .in_we     (in_we),
    .in_rg     (in_rg),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kill  (out_kill),
    .out_we    (out_we),
    .out_rg    (out_rg),
    .out_data  (out_data),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [39:0] d, input logic [3:0] rg, input logic [1:0] we, input logic k);
    in_valid = 1'b1;
    in_data  = d;
    in_rg    = rg;
    in_we    = we;
    in_kill  = k;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_kill = 1'b0;
    in_we = 2'b00; in_rg = 4'h0; in_data = '0; out_ready = 1'b0;

    // Reset for two cycles
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ",       64'(occ),       64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_stall",     64'(stall_cnt), 64'd0);
    rst_n = 1'b1;

    // 1. Streaming at full throughput
    out_ready = 1'b1;
    push(40'h11, 4'h1, 2'b00, 1'b0); tick();
    chk("t1_v0", 64'(out_valid), 64'd1);
    chk("t1_d0", 64'(out_data), 64'h11);
    chk("t1_o0", 64'(occ), 64'd1);
    push(40'h22, 4'h2, 2'b00, 1'b0); tick();
    chk("t1_d1", 64'(out_data), 64'h22);
    chk("t1_o1", 64'(occ), 64'd1);
    push(40'h33, 4'h3, 2'b00, 1'b0); tick();
    chk("t1_d2", 64'(out_data), 64'h33);
    chk("t1_o2", 64'(occ), 64'd1);
    chk("t1_rg2", 64'(out_rg), 64'h3);
    in_valid = 1'b0; tick();
    chk("t1_empty", 64'(out_valid), 64'd0);
    chk("t1_occ_end", 64'(occ), 64'd0);
    chk("t1_stall", 64'(stall_cnt), 64'd0);

    // 2. Backpressure fills the skid buffer
    out_ready = 1'b0;
    push(40'hA1, 4'h4, 2'b01, 1'b0); tick();
    chk("t2_occ1", 64'(occ), 64'd1);
    chk("t2_rdy1", 64'(in_ready), 64'd1);
    push(40'hA2, 4'h5, 2'b01, 1'b0); tick();
    chk("t2_occ2", 64'(occ), 64'd2);
    chk("t2_rdy0", 64'(in_ready), 64'd0);
    chk("t2_stall1", 64'(stall_cnt), 64'd1);
    push(40'hA3, 4'h6, 2'b01, 1'b0); tick();
    chk("t2_hold_occ", 64'(occ), 64'd2);
    chk("t2_d_a1", 64'(out_data), 64'hA1);
    chk("t2_stall2", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1; tick();
    chk("t2_d_a2", 64'(out_data), 64'hA2);
    chk("t2_occ_a2", 64'(occ), 64'd1);
    chk("t2_rdy_back", 64'(in_ready), 64'd1);
    tick();
    chk("t2_d_a3", 64'(out_data), 64'hA3);
    chk("t2_occ_a3", 64'(occ), 64'd1);
    in_valid = 1'b0; tick();
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_stall_end", 64'(stall_cnt), 64'd2);

    // 3. Kill suppresses write enables but keeps data
    push(40'hBEEF, 4'h7, 2'b11, 1'b1); tick();
    chk("t3_we_k", 64'(out_we), 64'd0);
    chk("t3_kill", 64'(out_kill), 64'd1);
    chk("t3_data", 64'(out_data), 64'hBEEF);
    push(40'h1234, 4'h8, 2'b01, 1'b0); tick();
    chk("t3_we_nk", 64'(out_we), 64'd1);
    chk("t3_kill0", 64'(out_kill), 64'd0);
    in_valid = 1'b0; in_kill = 1'b0; tick();

    // 4. Flush with a full stage and a pending input
    out_ready = 1'b0;
    push(40'hC1, 4'h1, 2'b00, 1'b0); tick();
    push(40'hC2, 4'h2, 2'b00, 1'b0); tick();
    chk("t4_occ2", 64'(occ), 64'd2);
    push(40'hC3, 4'h3, 2'b00, 1'b0); flush = 1'b1; tick();
    chk("t4_occ0", 64'(occ), 64'd0);
    chk("t4_vld0", 64'(out_valid), 64'd0);
    chk("t4_stall", 64'(stall_cnt), 64'd4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("t4_no_c3", 64'(out_valid), 64'd0);
    // Flush with room available: the offered entry must still be dropped
    out_ready = 1'b0;
    push(40'hE1, 4'h1, 2'b00, 1'b0); tick();
    chk("t4b_occ1", 64'(occ), 64'd1);
    push(40'hE2, 4'h2, 2'b00, 1'b0); flush = 1'b1; tick();
    chk("t4b_occ0", 64'(occ), 64'd0);
    chk("t4b_vld0", 64'(out_valid), 64'd0);
    chk("t4b_stall", 64'(stall_cnt), 64'd5);
    flush = 1'b0; in_valid = 1'b0;

    // 5. Reset in the middle of operation
    push(40'hD8, 4'h5, 2'b01, 1'b0); tick();
    push(40'hD9, 4'h6, 2'b10, 1'b0); tick();
    chk("t5_occ2", 64'(occ), 64'd2);
    chk("t5_stall", 64'(stall_cnt), 64'd6);
    in_valid = 1'b0; rst_n = 1'b0; flush = 1'b1; tick();
    chk("t5_vld", 64'(out_valid), 64'd0);
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_rg", 64'(out_rg), 64'd0);
    chk("t5_we", 64'(out_we), 64'd0);
    chk("t5_kill", 64'(out_kill), 64'd0);
    chk("t5_occ", 64'(occ), 64'd0);
    chk("t5_rdy", 64'(in_ready), 64'd1);
    chk("t5_stall0", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
    push(40'hD1, 4'h9, 2'b00, 1'b0); tick();
    chk("t5_d1", 64'(out_data), 64'hD1);
    chk("t5_d1_occ", 64'(occ), 64'd1);
    in_valid = 1'b0; tick();
    chk("t5_alone", 64'(out_valid), 64'd0);

    // 6. Stall counter saturation
    out_ready = 1'b0;
    push(40'h55, 4'h1, 2'b00, 1'b0); tick();
    in_valid = 1'b0;
    chk("t6_start", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("t6_14", 64'(stall_cnt), 64'd14);
    tick();
    chk("t6_15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_sat", 64'(stall_cnt), 64'd15);
    chk("t6_held", 64'(out_data), 64'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
